alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Sequencing stage wrapped around the 8-bit combinational alu.
- Buffers incoming operation commands in a small FIFO and drives registered operands and opcode into the alu.
- Captures the alu's result, carry and zero outputs into a registered result slot with a valid/ready handshake to the consumer.
- Turns the purely combinational alu into a flow-controlled pipeline stage.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- CW, 16, width of optional statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO, FSM and result slot.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  3  opcode: 0 add, 1 sub, 2 and, 3 or, 4 not-A, 5-7 invalid.
- alu_a  out  8  registered operand to alu.
- alu_b  out  8  registered operand to alu.
- alu_opcode  out  3  registered opcode to alu.
- alu_result  in  8  alu result, combinational from alu_a/alu_b/alu_opcode.
- alu_carry  in  1  alu carry_out.
- alu_zero  in  1  alu zero flag.
- res_valid  out  1  result slot holds a result.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured result.
- res_carry  out  1  captured carry.
- res_zero  out  1  captured zero.
- res_op  out  3  opcode that produced the result.
- res_err  out  1  1 if res_op was 5-7.
- stat_ops  out  CW  completed results (only with ALU_ISSUE_STATS_EN).
- stat_errs  out  CW  completed invalid-opcode results (only with ALU_ISSUE_STATS_EN).

Behaviour:
- Reset (async): all outputs 0, except cmd_ready = 1. FIFO empty, FSM in IDLE.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - Read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
  - No write bypass when full: a pop in the same cycle does not raise cmd_ready until the next cycle.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_opcode and go to EXEC; else stay.
  - EXEC: capture alu_result/alu_carry/alu_zero into res_data/res_carry/res_zero. Copy alu_opcode to res_op; set res_err = (alu_opcode >= 5). Assert res_valid. Go to HOLD.
  - HOLD: res_* held stable while res_valid && !res_ready. On res_ready, clear res_valid. Then, if FIFO non-empty, pop the next command into the operand registers and go to EXEC; otherwise go to IDLE.
- alu_a/alu_b/alu_opcode hold their last value when not popping.
- Latency: command accepted at edge N into an empty, idle block gives res_valid = 1 after edge N+2.
- Throughput: one result per 2 cycles with res_ready held high.
- res_carry is captured verbatim for every opcode; the consumer qualifies it with res_op.
- Flush:
  - Empties the FIFO, forces IDLE and clears res_valid/res_err.
  - Takes priority over push, pop and capture in the same cycle; cmd_ready is still driven as !full that cycle.
  - Operand registers are not cleared.
- Reset mid-operation discards FIFO contents and any pending result.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined:
  - stat_ops and stat_errs ports exist.
  - stat_ops increments on each result handshake (res_valid && res_ready); stat_errs increments when res_err is also 1.
  - Both saturate at all-ones.
  - Both clear on rst only; flush does not clear them.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single add: push A=0x0F, B=0x01, op=0 with res_ready=1 → res_valid 2 cycles after acceptance; res_data=0x10, res_op=0, res_err=0; res_zero and res_carry equal the alu outputs at capture.
- Backpressure: push 5 commands with res_ready=0 and DEPTH=4 → 1 command in the result slot, 4 in the FIFO. cmd_ready drops after the 5th accept, and a 6th offer stalls. res_* stays stable for 10 cycles. Releasing res_ready drains results in order with 1 result per 2 cycles.
- Invalid opcode: push op=6, A=0xAA, B=0x55 → res_data=0x00, res_zero=1, res_err=1.
- Flush: with FIFO holding 3 commands and res_valid=1, pulse flush together with cmd_valid → next cycle res_valid=0, FIFO empty, flushed-cycle command not stored, cmd_ready=1.
- Async reset: assert rst mid-HOLD between clock edges → outputs go to reset values immediately; after release a new add completes normally.
- Stats (macro defined): complete 3 valid ops and 2 invalid ops, then flush → stat_ops=5, stat_errs=2; force 2^CW+1 completions → stat_ops stays at all-ones.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage that turns a combinational 8-bit alu into a valid/ready stage.
// Define ALU_ISSUE_STATS_EN to add the saturating stat_ops/stat_errs counters.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic [2:0]    cmd_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [7:0]    alu_result,
  input  logic          alu_carry,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic          res_carry,
  output logic          res_zero,
  output logic [2:0]    res_op,
  output logic          res_err
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [CW-1:0] stat_ops,
  output logic [CW-1:0] stat_errs
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CW < 1) begin : g_bad_cfg
    $error("alu_issue_ctrl: DEPTH must be a power of 2 >= 2, CW >= 1");
  end

  logic [18:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [1:0]      state;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            want_pop;

  assign full      = (count == CNTW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;
  assign pop       = want_pop && !flush;

  always_comb begin
    want_pop = 1'b0;
    case (state)
      IDLE:    want_pop = !empty;
      HOLD:    want_pop = res_ready && !empty;
      default: want_pop = 1'b0;
    endcase
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (pop) begin
      {alu_opcode, alu_a, alu_b} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_op    <= '0;
      res_err   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) state <= EXEC;
        end
        EXEC: begin
          res_data  <= alu_result;
          res_carry <= alu_carry;
          res_zero  <= alu_zero;
          res_op    <= alu_opcode;
          res_err   <= (alu_opcode >= 3'd5);
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= empty ? IDLE : EXEC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic hs;
  assign hs = res_valid && res_ready;

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else begin
      if (hs && (stat_ops != '1))
        stat_ops <= stat_ops + CW'(1);
      if (hs && res_err && (stat_errs != '1))
        stat_errs <= stat_errs + CW'(1);
    end
  end
`endif

endmodule
